// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM feedback capture block.
package pwm_pkg;

    localparam int unsigned CNT_WIDTH_DEF = 16;
    localparam int unsigned CNT_WIDTH_MAX = 32;

    // Reported for a result field whose edge did not occur within the period;
    // sliced down to the counter width by the users.
    localparam logic [CNT_WIDTH_MAX-1:0] CNT_MISSING = '1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } cap_state_e;

endpackage

// File: rtl/pwm_feedback_capture_if.sv
// Result bus of the PWM feedback capture: measurements, strobe and sticky flags.
interface pwm_feedback_capture_if
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) ();

    logic [CNT_WIDTH-1:0] period_o;
    logic [CNT_WIDTH-1:0] high_time_o;
    logic [CNT_WIDTH-1:0] dt_rise_o;
    logic [CNT_WIDTH-1:0] dt_fall_o;
    logic                 valid_o;
    logic                 shoot_through_o;
    logic                 timeout_o;

    // Capture block drives the results.
    modport master (
        output period_o, high_time_o, dt_rise_o, dt_fall_o,
        output valid_o, shoot_through_o, timeout_o
    );

    // Control/monitoring side samples them on valid_o.
    modport slave (
        input period_o, high_time_o, dt_rise_o, dt_fall_o,
        input valid_o, shoot_through_o, timeout_o
    );

endinterface

// File: rtl/pwm_edge_sync.sv
// Synchronizer for one asynchronous feedback pin plus registered edge pulses.
// rise_o/fall_o are aligned with each other; sync_o is the raw synchronized level.
module pwm_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_q;
    logic                   rise_q;
    logic                   fall_q;

    // Metastability chain for the asynchronous pin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    // Edge detector with registered single-cycle pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            lvl_q  <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~lvl_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & lvl_q;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/pwm_feedback_capture.sv
// Measures period, high-side on-time and both dead times of one complementary
// PWM leg from the driver feedback, and flags shoot-through and missing PWM.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | counters held at 0, waiting for the first high-side rise
// ST_MEASURE | period counter running, results latched on each high-side rise
module pwm_feedback_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic                          clear_i,
    input  logic [1:0]                    pwm_i,
    pwm_feedback_capture_if.master        cap_if
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_MISSING[CNT_WIDTH-1:0];
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic s0, s1, rise0, fall0, rise1, fall1;

    cap_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_WIDTH-1:0] dtf_cnt_q, dtf_cnt_d;
    logic [CNT_WIDTH-1:0] dtr_cnt_q, dtr_cnt_d;
    logic                 dtf_run_q, dtf_run_d;
    logic                 dtr_run_q, dtr_run_d;
    logic [CNT_WIDTH-1:0] high_cap_q, high_cap_d;
    logic [CNT_WIDTH-1:0] dtf_cap_q, dtf_cap_d;
    logic                 got_high_q, got_high_d;
    logic                 got_dtf_q, got_dtf_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
    logic [CNT_WIDTH-1:0] dt_rise_q, dt_rise_d;
    logic [CNT_WIDTH-1:0] dt_fall_q, dt_fall_d;
    logic                 valid_q, valid_d;
    logic                 shoot_q, shoot_d;
    logic                 timeout_q, timeout_d;

    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_hs (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (pwm_i[0]),
        .sync_o  (s0),
        .rise_o  (rise0),
        .fall_o  (fall0)
    );

    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ls (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (pwm_i[1]),
        .sync_o  (s1),
        .rise_o  (rise1),
        .fall_o  (fall1)
    );

    // Next-state, counters, result latching and flag logic.
    always_comb begin
        state_d     = state_q;
        per_cnt_d   = per_cnt_q;
        dtf_cnt_d   = dtf_cnt_q;
        dtr_cnt_d   = dtr_cnt_q;
        dtf_run_d   = dtf_run_q;
        dtr_run_d   = dtr_run_q;
        high_cap_d  = high_cap_q;
        dtf_cap_d   = dtf_cap_q;
        got_high_d  = got_high_q;
        got_dtf_d   = got_dtf_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        dt_rise_d   = dt_rise_q;
        dt_fall_d   = dt_fall_q;
        valid_d     = 1'b0;
        // A set condition wins over a simultaneous clear.
        shoot_d     = (shoot_q & ~clear_i) | (enable_i & s0 & s1);
        timeout_d   = timeout_q & ~clear_i;

        if (!enable_i || state_q == ST_IDLE) begin
            per_cnt_d  = '0;
            dtf_cnt_d  = '0;
            dtr_cnt_d  = '0;
            dtf_run_d  = 1'b0;
            dtr_run_d  = 1'b0;
            got_high_d = 1'b0;
            got_dtf_d  = 1'b0;
        end

        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The first rise only arms the measurement; nothing to report yet.
                    if (rise0) begin
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    per_cnt_d = per_cnt_q + CNT_ONE;
                    if (dtf_run_q) begin
                        dtf_cnt_d = sat_inc(dtf_cnt_q);
                    end
                    if (dtr_run_q) begin
                        dtr_cnt_d = sat_inc(dtr_cnt_q);
                    end
                    if (fall0) begin
                        high_cap_d = sat_inc(per_cnt_q);
                        got_high_d = 1'b1;
                        dtf_cnt_d  = '0;
                        dtf_run_d  = 1'b1;
                    end
                    // Low-side rise only counts after a high-side fall in this period.
                    if (rise1 && (fall0 || dtf_run_q)) begin
                        dtf_cap_d = fall0 ? CNT_ONE : sat_inc(dtf_cnt_q);
                        got_dtf_d = 1'b1;
                        dtf_run_d = 1'b0;
                    end
                    if (fall1) begin
                        dtr_cnt_d = '0;
                        dtr_run_d = 1'b1;
                    end
                    if (rise0) begin
                        valid_d     = 1'b1;
                        period_d    = sat_inc(per_cnt_q);
                        high_time_d = got_high_q ? high_cap_q : CNT_MAX;
                        dt_fall_d   = got_dtf_q ? dtf_cap_q : CNT_MAX;
                        dt_rise_d   = fall1 ? CNT_ONE :
                                      (dtr_run_q ? sat_inc(dtr_cnt_q) : CNT_MAX);
                        per_cnt_d   = '0;
                        dtf_cnt_d   = '0;
                        dtr_cnt_d   = '0;
                        dtf_run_d   = 1'b0;
                        dtr_run_d   = 1'b0;
                        got_high_d  = 1'b0;
                        got_dtf_d   = 1'b0;
                    end else if (per_cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                        per_cnt_d = '0;
                        dtf_run_d = 1'b0;
                        dtr_run_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counter and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            per_cnt_q   <= '0;
            dtf_cnt_q   <= '0;
            dtr_cnt_q   <= '0;
            dtf_run_q   <= 1'b0;
            dtr_run_q   <= 1'b0;
            high_cap_q  <= '0;
            dtf_cap_q   <= '0;
            got_high_q  <= 1'b0;
            got_dtf_q   <= 1'b0;
            period_q    <= '0;
            high_time_q <= '0;
            dt_rise_q   <= '0;
            dt_fall_q   <= '0;
            valid_q     <= 1'b0;
            shoot_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            dtf_cnt_q   <= dtf_cnt_d;
            dtr_cnt_q   <= dtr_cnt_d;
            dtf_run_q   <= dtf_run_d;
            dtr_run_q   <= dtr_run_d;
            high_cap_q  <= high_cap_d;
            dtf_cap_q   <= dtf_cap_d;
            got_high_q  <= got_high_d;
            got_dtf_q   <= got_dtf_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            dt_rise_q   <= dt_rise_d;
            dt_fall_q   <= dt_fall_d;
            valid_q     <= valid_d;
            shoot_q     <= shoot_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cap_if.period_o        = period_q;
    assign cap_if.high_time_o     = high_time_q;
    assign cap_if.dt_rise_o       = dt_rise_q;
    assign cap_if.dt_fall_o       = dt_fall_q;
    assign cap_if.valid_o         = valid_q;
    assign cap_if.shoot_through_o = shoot_q;
    assign cap_if.timeout_o       = timeout_q;

endmodule

// File: tb/tb_pwm_feedback_capture.sv
// Directed bench for pwm_feedback_capture with CNT_WIDTH=8, SYNC_STAGES=2.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_pwm_feedback_capture;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       clear;
    logic [1:0] pwm;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned vcount;
    int unsigned vbase;
    logic [7:0]  v_period, v_high, v_dtr, v_dtf;
    logic        prev_valid;

    pwm_feedback_capture_if #(.CNT_WIDTH(8)) cap_if ();

    pwm_feedback_capture #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .enable_i (enable),
        .clear_i  (clear),
        .pwm_i    (pwm),
        .cap_if   (cap_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Valid-strobe monitor: records the latest results and checks strobe width.
    initial prev_valid = 1'b0;
    always @(posedge clk) begin
        #1;
        if (cap_if.valid_o === 1'b1) begin
            check_eq("valid_width", 32'(prev_valid), 0);
            vcount++;
            v_period = cap_if.period_o;
            v_high   = cap_if.high_time_o;
            v_dtr    = cap_if.dt_rise_o;
            v_dtf    = cap_if.dt_fall_o;
        end
        prev_valid = cap_if.valid_o;
    end

    task automatic drive_span(input int p, input int h, input int d, input bit ls,
                              input int t0, input int t1);
        for (int t = t0; t <= t1; t++) begin
            @(negedge clk);
            pwm[0] = (t < h);
            pwm[1] = ls && (t >= h + d) && (t < p - d);
        end
    endtask

    task automatic drive_period(input int p, input int h, input int d, input bit ls);
        drive_span(p, h, d, ls, 0, p - 1);
    endtask

    task automatic check_results(input string tag, input int p, input int h,
                                 input int dr, input int df);
        check_eq({tag, "_period"}, 32'(v_period), p);
        check_eq({tag, "_high"},   32'(v_high),   h);
        check_eq({tag, "_dtrise"}, 32'(v_dtr),    dr);
        check_eq({tag, "_dtfall"}, 32'(v_dtf),    df);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        vcount   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        clear    = 1'b0;
        pwm      = 2'b00;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_period",  32'(cap_if.period_o), 0);
        check_eq("rst_high",    32'(cap_if.high_time_o), 0);
        check_eq("rst_dtrise",  32'(cap_if.dt_rise_o), 0);
        check_eq("rst_dtfall",  32'(cap_if.dt_fall_o), 0);
        check_eq("rst_valid",   32'(cap_if.valid_o), 0);
        check_eq("rst_shoot",   32'(cap_if.shoot_through_o), 0);
        check_eq("rst_timeout", 32'(cap_if.timeout_o), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Complementary PWM 100/40 with 5 cycles dead time each side.
        repeat (4) drive_period(100, 40, 5, 1'b1);
        check_eq("nominal_valid_count", vcount, 3);
        check_results("nominal", 100, 40, 5, 5);

        // Disable for 3 periods, then re-arm.
        @(negedge clk);
        enable = 1'b0;
        vbase  = vcount;
        repeat (3) drive_period(100, 40, 5, 1'b1);
        check_eq("dis_no_valid", vcount, vbase);
        check_eq("dis_retained_period", 32'(cap_if.period_o), 100);
        enable = 1'b1;
        drive_period(100, 40, 5, 1'b1);
        check_eq("reen_first_edge", vcount, vbase);
        drive_period(100, 40, 5, 1'b1);
        check_eq("reen_second_edge", vcount, vbase + 1);
        check_results("reen", 100, 40, 5, 5);

        // Low side silent, high side period 50 / high 20.
        vbase = vcount;
        repeat (3) drive_period(50, 20, 5, 1'b0);
        check_eq("nols_valid_count", vcount, vbase + 3);
        check_results("nols", 50, 20, 255, 255);

        // Single high-side pulse from IDLE, then nothing: period counter saturates.
        @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        pwm = 2'b01;
        repeat (20) @(posedge clk);
        @(negedge clk);
        pwm = 2'b00;
        repeat (239) @(posedge clk);
        #1 check_eq("timeout_before_sat", 32'(cap_if.timeout_o), 0);
        @(posedge clk);
        #1 check_eq("timeout_at_sat", 32'(cap_if.timeout_o), 1);
        vbase = vcount;
        drive_period(100, 40, 5, 1'b1);
        check_eq("to_first_rise", vcount, vbase);
        drive_period(100, 40, 5, 1'b1);
        check_eq("to_second_rise", vcount, vbase + 1);
        check_results("to", 100, 40, 5, 5);
        check_eq("timeout_sticky", 32'(cap_if.timeout_o), 1);

        // Shoot-through for 2 cycles.
        @(negedge clk);
        pwm = 2'b11;
        repeat (2) @(posedge clk);
        #1 check_eq("st_latency_early", 32'(cap_if.shoot_through_o), 0);
        @(negedge clk);
        pwm = 2'b00;
        @(posedge clk);
        #1 check_eq("st_set", 32'(cap_if.shoot_through_o), 1);
        repeat (10) @(posedge clk);
        #1 check_eq("st_sticky", 32'(cap_if.shoot_through_o), 1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_eq("st_cleared", 32'(cap_if.shoot_through_o), 0);
        check_eq("timeout_cleared", 32'(cap_if.timeout_o), 0);

        // Clear pulsed while the overlap is still present.
        @(negedge clk);
        pwm = 2'b11;
        repeat (3) @(posedge clk);
        #1 check_eq("st_reset_overlap", 32'(cap_if.shoot_through_o), 1);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 check_eq("st_clear_vs_set", 32'(cap_if.shoot_through_o), 1);
        @(negedge clk);
        clear = 1'b0;
        pwm   = 2'b00;
        repeat (5) @(posedge clk);
        #1 check_eq("st_after_overlap", 32'(cap_if.shoot_through_o), 1);

        // Asynchronous reset mid-period with a flag set.
        drive_span(100, 40, 5, 1'b1, 0, 29);
        #1;
        check_eq("pre_rst_shoot", 32'(cap_if.shoot_through_o), 1);
        check_eq("pre_rst_period_nz", 32'(cap_if.period_o != 8'd0), 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_period",  32'(cap_if.period_o), 0);
        check_eq("arst_high",    32'(cap_if.high_time_o), 0);
        check_eq("arst_dtrise",  32'(cap_if.dt_rise_o), 0);
        check_eq("arst_dtfall",  32'(cap_if.dt_fall_o), 0);
        check_eq("arst_valid",   32'(cap_if.valid_o), 0);
        check_eq("arst_shoot",   32'(cap_if.shoot_through_o), 0);
        check_eq("arst_timeout", 32'(cap_if.timeout_o), 0);
        drive_span(100, 40, 5, 1'b1, 30, 59);
        rst_n = 1'b1;
        vbase = vcount;
        drive_span(100, 40, 5, 1'b1, 60, 99);
        drive_period(100, 40, 5, 1'b1);
        check_eq("post_rst_first_rise", vcount, vbase);
        drive_period(100, 40, 5, 1'b1);
        check_eq("post_rst_second_rise", vcount, vbase + 1);
        check_results("post_rst", 100, 40, 5, 5);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
